clk_divider_multi: RTL
======================

# clk_divider_multi

Parametrised multi-channel clock divider. It is the successor to the fixed single-output divider and drives the stopwatch display multiplex, the debounce sampling and the time base from one counter bank. Each channel has a runtime-programmable half-period, a 50 % duty square-wave output and a one-cycle tick strobe. Reprogramming is glitch-free: a new value takes effect only at a period boundary. A global sync restarts all channels in phase.

## Interface
- `N_CH`, default 2: number of independent divider channels, 1 to 8.
- `DIV_W`, default 24: width of the half-period value and of each channel counter.
- `DEFAULT_HALF`, default 500_000: half-period loaded into every channel at reset. Must be below 2**DIV_W.
- `clk100MHz`, in, 1: single system clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `en`, in, 1: global count enable. While low, all channels freeze.
- `sync`, in, 1: one-cycle synchronous phase restart of all channels.
- `wr_en`, in, 1: write strobe for a new half-period.
- `wr_ch`, in, $clog2(N_CH) (min 1): target channel of the write.
- `wr_half`, in, DIV_W: new half-period in clk100MHz cycles. 0 stops the channel.
- `clk_div`, out, N_CH: square-wave outputs, one bit per channel.
- `tick`, out, N_CH: one-cycle strobe, high in the same cycle `clk_div` toggles.
- `wr_ack`, out, N_CH: one-cycle strobe, high when a pending value is applied to that channel.

## Operation
- Per channel state: `count[DIV_W]`, `half[DIV_W]`, `pend_half[DIV_W]`, `pending`. All outputs are registered.
- Reset (rst_n=0 at an edge) sets: count=0, half=DEFAULT_HALF, pending=0, pend_half=0, clk_div=0, tick=0, wr_ack=0. Reset overrides all other inputs.
- Counting, when en=1, half≠0 and sync=0:
  - If count == half−1 (wrap): count←0, clk_div toggles, tick←1. If pending=1, half←pend_half, pending←0, wr_ack←1.
  - Otherwise count←count+1 and tick←0.
- Output period is 2·half cycles with exact 50 % duty. Tick spacing is half cycles. half=1 toggles clk_div every cycle with tick held high.
- When en=0, count, clk_div and pending hold, and tick=0. No value is applied while en=0.
- Stopped channel, half=0: count=0, clk_div=0, tick=0. A pending value is applied in the cycle after it is written, regardless of en, with count←0, clk_div←0 and wr_ack←1.
- Write: wr_en=1 with wr_ch<N_CH sets pend_half←wr_half and pending←1 for that channel. A later write before the apply overwrites it; the last write wins and only one wr_ack is issued. wr_ch≥N_CH is ignored silently.
- Write in the same cycle as a wrap: the wrap applies the previously pending value, if any, with wr_ack. The new write becomes pending for the next wrap.
- Sync, when sync=1 and rst_n=1: every channel sets count←0 and clk_div←0, tick=0. Any pending value is applied with wr_ack. Sync takes priority over wrap and over en=0. A write in the same cycle as sync is captured as pending and not applied by that sync.
- Counter arithmetic is unsigned DIV_W. count never exceeds half−1, so there is no overflow path. If half is lowered below the current count, the change applies only at a wrap or sync, where count=0, so the comparison stays valid.

## Timing
- Latency from a wrap condition to the clk_div toggle is one edge; count, clk_div, tick and wr_ack update on the same edge.
- After reset release with en=1, the first tick and clk_div rise occur DEFAULT_HALF cycles after the first enabled edge.
- After sync at edge k, the first tick occurs at edge k+half, and all channels with equal half stay phase-aligned.
- Write-to-apply latency:
  - minimum 1 cycle, for a stopped channel or a write one cycle before a wrap;
  - maximum half+1 enabled cycles.
- Combinational paths from inputs to outputs: none.

## Test plan
- Reset and free-run, DEFAULT_HALF=4, N_CH=2, en=1: clk_div toggles every 4 cycles (period 8), tick high 1 of every 4 cycles, wr_ack=0. rst_n=0 mid-period returns all outputs to 0 on the next edge.
- Reprogram: write ch0 half=2 at count=1 → ch0 continues at 4 until its wrap, wr_ack[0] is high at that wrap, then period is 4. ch1 is unchanged.
- Back-to-back writes: half=6 then half=3 to ch1 before a wrap → a single wr_ack[1], and the new period is 6.
- Write in the same cycle as a wrap with pending=0 → no ack at that wrap; applied with wr_ack at the following wrap.
- Stop and start: write half=0 → after the next wrap, clk_div stays 0 with no ticks. Then write half=5 → wr_ack the next cycle, and the first tick 5 enabled cycles later.
- en and sync: en=0 for 10 cycles freezes clk_div and count with tick=0; on resume, counting continues from the frozen count. Sync with channels at different counts → both clk_div=0 next cycle, pending applied, and ticks aligned for equal half.

Source files
------------

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: bank of runtime-programmable 50 % duty clock dividers with tick strobes
module clk_divider_multi #(
    parameter int N_CH         = 2,
    parameter int DIV_W        = 24,
    parameter int DEFAULT_HALF = 500_000,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk100MHz,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_half,
    output logic [N_CH-1:0]   clk_div,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   wr_ack
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [DIV_W-1:0] count, half, pend_half;
        logic [DIV_W-1:0] count_d, half_d, pend_half_d;
        logic             pending, pending_d;
        logic             div_q, tick_q, ack_q;
        logic             div_d, tick_d, ack_d;
        logic             apply, wr_hit;

        // a matching index can only name an existing channel, so out-of-range writes fall through
        assign wr_hit = wr_en && (wr_ch == CH_W'(g));

        // next state: sync beats stop beats freeze beats counting; a new half is only taken where count is 0
        always_comb begin
            count_d     = count;
            half_d      = half;
            pend_half_d = pend_half;
            pending_d   = pending;
            div_d       = div_q;
            tick_d      = 1'b0;
            ack_d       = 1'b0;
            apply       = 1'b0;
            if (sync || half == '0) begin
                count_d = '0;
                div_d   = 1'b0;
                apply   = pending;
            end else if (en) begin
                if (count == half - DIV_W'(1)) begin
                    count_d = '0;
                    div_d   = ~div_q;
                    tick_d  = 1'b1;
                    apply   = pending;
                end else begin
                    count_d = count + DIV_W'(1);
                end
            end
            if (apply) begin
                half_d    = pend_half;
                pending_d = 1'b0;
                ack_d     = 1'b1;
            end
            if (wr_hit) begin
                pend_half_d = wr_half;
                pending_d   = 1'b1;
            end
        end

        // channel state register with synchronous active-low reset
        always_ff @(posedge clk100MHz) begin
            if (!rst_n) begin
                count     <= '0;
                half      <= DIV_W'(DEFAULT_HALF);
                pend_half <= '0;
                pending   <= 1'b0;
                div_q     <= 1'b0;
                tick_q    <= 1'b0;
                ack_q     <= 1'b0;
            end else begin
                count     <= count_d;
                half      <= half_d;
                pend_half <= pend_half_d;
                pending   <= pending_d;
                div_q     <= div_d;
                tick_q    <= tick_d;
                ack_q     <= ack_d;
            end
        end

        assign clk_div[g] = div_q;
        assign tick[g]    = tick_q;
        assign wr_ack[g]  = ack_q;
    end

endmodule
